// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, table entry layout and BHT counter encoding for the
// branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_BITS  = 6;
  localparam int TAG_BITS    = DATA_WIDTH - 2 - INDEX_BITS;
  localparam int NUM_ENTRIES = 1 << INDEX_BITS;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] target;
  } btb_entry_t;

  // Saturating step of a 2-bit direction counter.
  function automatic bht_ctr_t bht_next(input bht_ctr_t cur, input logic taken);
    bht_ctr_t nxt;
    nxt = cur;
    if (taken && cur != ST) nxt = cur + 2'd1;
    else if (!taken && cur != SNT) nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_sat_counter_table.sv
// Direct-mapped array of 2-bit saturating direction counters.
// One combinational read port for fetch, one synchronous update port
// that either steps the counter or loads a fresh value on allocation.
module bht_sat_counter_table
  import branch_resolve_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_ctr,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_load,
  input  logic [1:0]            upd_load_val,
  input  logic                  upd_taken
);

  bht_ctr_t ctr [NUM_ENTRIES];

  // Read is unbypassed: a same-cycle update is seen on the next cycle.
  assign rd_ctr = ctr[rd_idx];

  // Reset every entry to weakly not-taken; otherwise load or step one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ctr[i] <= WNT;
    end else if (upd_en) begin
      if (upd_load) ctr[upd_idx] <= upd_load_val;
      else          ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch-time branch prediction (BTB + BHT) and execute-time resolution.
// A misprediction produces a one-cycle flush on rst_out with the
// corrected fetch PC on redirect_pc; anything resolving during that
// flush cycle is wrong-path and is ignored.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_BF,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  output logic                  rst_out,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  btb_entry_t btb [NUM_ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  btb_entry_t            if_entry, ex_entry;
  logic [1:0]            if_ctr;
  logic                  live, ex_hit, mispredict, flush_req;
  logic                  bht_upd_en, bht_upd_load;
  logic                  btb_write, btb_inval;

  assign if_idx   = if_pc[INDEX_BITS+1:2];
  assign if_tag   = if_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign ex_idx   = ex_pc[INDEX_BITS+1:2];
  assign ex_tag   = ex_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign if_entry = btb[if_idx];
  assign ex_entry = btb[ex_idx];

  bht_sat_counter_table u_bht (
    .clk          (clk),
    .rst          (rst_BF),
    .rd_idx       (if_idx),
    .rd_ctr       (if_ctr),
    .upd_en       (bht_upd_en),
    .upd_idx      (ex_idx),
    .upd_load     (bht_upd_load),
    .upd_load_val (WT),
    .upd_taken    (ex_taken)
  );

  // Fetch lookup: taken only on a valid tag hit with an upper-half counter.
  always_comb begin
    pred_taken  = if_entry.valid && (if_entry.tag == if_tag) && if_ctr[1];
    pred_target = pred_taken ? if_entry.target : if_pc + DATA_WIDTH'(4);
  end

  // Resolve: misprediction detect and table update decisions.
  always_comb begin
    live   = ex_valid && !rst_out;
    ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);
    if (ex_is_branch)
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
    else
      mispredict = ex_pred_taken;
    flush_req = live && mispredict;
    // A not-taken branch that misses the tag leaves the table alone;
    // a taken branch that misses allocates with a weakly-taken counter.
    bht_upd_en   = live && ex_is_branch && (ex_taken || ex_hit);
    bht_upd_load = ex_taken && !ex_hit;
    btb_write    = live && ex_is_branch && ex_taken;
    btb_inval    = live && !ex_is_branch && ex_pred_taken;
  end

  // BTB storage: only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      for (int i = 0; i < NUM_ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (btb_write) begin
      btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target};
    end else if (btb_inval) begin
      btb[ex_idx].valid <= 1'b0;
    end
  end

  // Flush pulse and redirect PC; redirect_pc holds between flushes.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      rst_out     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      rst_out <= flush_req;
      if (flush_req)
        redirect_pc <= ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
    end
  end

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (live && ex_is_branch) branch_count <= branch_count + 32'd1;
      if (flush_req)            mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_BF;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        rst_out;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  bit          m_valid  [64];
  logic [23:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_bht    [64];
  logic        m_rst_out;
  logic [31:0] m_redirect, m_bc, m_mc;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst_BF           (rst_BF),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .rst_out          (rst_out),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_pred(input logic [31:0] pc, output logic t,
                                     output logic [31:0] tg);
    int          i;
    logic [31:0] tag32;
    i     = int'((pc / 4) % 64);
    tag32 = pc / 256;
    t  = m_valid[i] && (m_tag[i] == tag32[23:0]) && (m_bht[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic void model_update();
    int          i;
    logic [31:0] tag32;
    bit          live, hit, mis;
    if (rst_BF) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 0;
        m_bht[k]   = 1;
      end
      m_rst_out  = 0;
      m_redirect = 0;
      m_bc       = 0;
      m_mc       = 0;
      return;
    end
    live  = ex_valid && !m_rst_out;
    mis   = 0;
    i     = int'((ex_pc / 4) % 64);
    tag32 = ex_pc / 256;
    hit   = m_valid[i] && (m_tag[i] == tag32[23:0]);
    if (live) begin
      if (ex_is_branch) begin
        m_bc = m_bc + 1;
        mis = (ex_taken != ex_pred_taken) ||
              (ex_taken && ex_pred_taken && ex_target != ex_pred_target);
        if (ex_taken) begin
          m_bht[i]    = hit ? ((m_bht[i] == 3) ? 3 : m_bht[i] + 1) : 2;
          m_valid[i]  = 1;
          m_tag[i]    = tag32[23:0];
          m_target[i] = ex_target;
        end else if (hit) begin
          m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
        end
      end else if (ex_pred_taken) begin
        mis = 1;
        m_valid[i] = 0;
      end
    end
    m_rst_out = mis;
    if (mis) begin
      m_redirect = ex_taken ? ex_target : ex_pc + 32'd4;
      m_mc = m_mc + 1;
    end
  endfunction

  task automatic compare_all();
    logic        t;
    logic [31:0] tg;
    model_pred(if_pc, t, tg);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, t});
    check("pred_target", pred_target, tg);
    check("rst_out", {31'd0, rst_out}, {31'd0, m_rst_out});
    check("redirect_pc", redirect_pc, m_redirect);
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic resolve(input logic br, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'h100 + 32'($urandom_range(0, 1)) * 32'h1000 + 32'($urandom_range(0, 3)) * 4;
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0: return 32'h200;
      1: return 32'h300;
      2: return 32'h400;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    rst_BF = 1; if_pc = 32'h100;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    tick(); tick();
    rst_BF = 0;

    // Reset state and cold lookup
    tick();
    check("t1_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("t1_pred_target", pred_target, 32'h104);
    check("t1_rst_out", {31'd0, rst_out}, 32'd0);
    check("t1_counts", branch_count | mispredict_count, 32'd0);

    // First taken branch mispredicts and allocates
    resolve(1, 32'h100, 1, 32'h200, 0, 32'h104);
    tick();
    check("t2_rst_out", {31'd0, rst_out}, 32'd1);
    check("t2_redirect", redirect_pc, 32'h200);
    check("t2_mcount", mispredict_count, 32'd1);
    check("t2_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("t2_pred_target", pred_target, 32'h200);
    ex_valid = 0;
    tick();
    check("t2_pulse_end", {31'd0, rst_out}, 32'd0);

    // Correct predictions saturate, then one not-taken flush
    for (int k = 0; k < 3; k++) begin
      resolve(1, 32'h100, 1, 32'h200, 1, 32'h200);
      tick();
      check("t3_no_flush", {31'd0, rst_out}, 32'd0);
    end
    resolve(1, 32'h100, 0, 32'h200, 1, 32'h200);
    tick();
    check("t3_rst_out", {31'd0, rst_out}, 32'd1);
    check("t3_redirect", redirect_pc, 32'h104);
    check("t3_still_taken", {31'd0, pred_taken}, 32'd1);
    check("t3_bcount", branch_count, 32'd5);
    ex_valid = 0;
    tick();

    // Right direction, wrong target
    resolve(1, 32'h100, 1, 32'h300, 1, 32'h200);
    tick();
    check("t4_rst_out", {31'd0, rst_out}, 32'd1);
    check("t4_redirect", redirect_pc, 32'h300);
    check("t4_pred_target", pred_target, 32'h300);
    ex_valid = 0;
    tick();

    // Back-to-back mispredict: the second lands in the flush cycle
    resolve(1, 32'h100, 0, 32'h300, 1, 32'h300);
    tick();
    check("t5_first_flush", {31'd0, rst_out}, 32'd1);
    check("t5_mcount_a", mispredict_count, 32'd4);
    resolve(1, 32'h104, 1, 32'h500, 0, 32'h108);
    if_pc = 32'h104;
    tick();
    check("t5_second_ignored", {31'd0, rst_out}, 32'd0);
    check("t5_mcount_b", mispredict_count, 32'd4);
    check("t5_not_installed", {31'd0, pred_taken}, 32'd0);
    ex_valid = 0; if_pc = 32'h100;
    tick();

    // Reset collides with a mispredicting resolve
    resolve(1, 32'h100, 0, 32'h300, 1, 32'h300);
    rst_BF = 1;
    tick();
    check("t6_rst_out", {31'd0, rst_out}, 32'd0);
    check("t6_counts", branch_count | mispredict_count, 32'd0);
    check("t6_redirect", redirect_pc, 32'd0);
    check("t6_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("t6_pred_target", pred_target, 32'h104);
    rst_BF = 0; ex_valid = 0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic        t;
      logic [31:0] tg;
      rst_BF       = ($urandom_range(0, 199) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_is_branch = ($urandom_range(0, 4) != 0);
      ex_pc        = rand_pc();
      ex_taken     = 1'($urandom_range(0, 1));
      ex_target    = rand_target();
      if ($urandom_range(0, 3) != 0) begin
        model_pred(ex_pc, t, tg);
        ex_pred_taken  = t;
        ex_pred_target = tg;
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = rand_target();
      end
      if_pc = ($urandom_range(0, 2) == 0) ? ex_pc : rand_pc();
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Producer of the core's misprediction flush `rst_out`, the per-cycle pulse the system benches count as mispredictions.
- Predicts at fetch using a direct-mapped BTB with 2-bit saturating BHT counters.
- Compares each resolved control-flow instruction against its carried prediction at execute, then issues a one-cycle flush plus a redirect PC.
- Keeps 32-bit branch and misprediction counters for performance dumps.

Parameters:
- DATA_WIDTH, 32, PC and target width.
- INDEX_BITS, 6, log2 of BTB/BHT entries (64).
- TAG_BITS, DATA_WIDTH-2-INDEX_BITS (24), BTB tag width, from PC[31:8] at defaults.

Ports:
- clk  in  1  core clock.
- rst_BF  in  1  synchronous active-high reset.
- if_pc  in  DATA_WIDTH  fetch PC.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  DATA_WIDTH  predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  execute stage holds a live instruction.
- ex_is_branch  in  1  instruction is branch/JAL/JALR.
- ex_pc  in  DATA_WIDTH  PC of the execute instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  DATA_WIDTH  actual target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  DATA_WIDTH  predicted target carried down the pipe.
- rst_out  out  1  flush pulse.
- redirect_pc  out  DATA_WIDTH  correct fetch PC, valid while rst_out=1.
- branch_count  out  32  resolved control-flow instructions.
- mispredict_count  out  32  flushes issued.

Behaviour:
- Reset (rst_BF=1 at posedge):
  - All BHT counters go to 01 (weakly not-taken); all BTB valid bits clear.
  - rst_out=0, redirect_pc=0, both counters=0.
  - Reset wins over any same-cycle resolve.
  - Reset mid-flush drops the pending flush.
- Lookup (combinational):
  - idx = if_pc[INDEX_BITS+1:2]; tag = if_pc[DATA_WIDTH-1:INDEX_BITS+2].
  - pred_taken = valid[idx] & tag match & bht[idx][1].
  - pred_target = btb_target[idx] if pred_taken, else if_pc+4 (mod 2^32).
- Resolve is live when ex_valid=1 and rst_out=0; an instruction resolving in the flush cycle is wrong-path and is ignored entirely.
- Misprediction (live resolve):
  - Branch (ex_is_branch=1) mispredicts when ex_taken != ex_pred_taken, or when ex_taken & ex_pred_taken & ex_target != ex_pred_target.
  - Non-branch mispredicts when ex_pred_taken=1 (BTB alias).
- Flush timing: a misprediction resolved at edge N drives rst_out=1 for exactly the cycle after edge N. redirect_pc is ex_target if ex_taken, else ex_pc+4. It is registered with rst_out and holds its value when rst_out=0.
- Table update at the same edge, live resolve only:
  - Branch: bht[idx] saturating +1 if taken, -1 if not (11 and 00 saturate).
  - Taken branch: write tag, target, valid=1. On a tag miss, overwrite the entry and set its counter to 10.
  - Non-branch with ex_pred_taken=1: clear valid[idx].
  - A not-taken branch whose tag misses leaves the table untouched.
- Same-index lookup and update in one cycle: lookup sees the pre-update value (no bypass).
- Counters:
  - branch_count +1 per live resolve with ex_is_branch=1.
  - mispredict_count +1 per rst_out pulse.
  - Both wrap modulo 2^32.
- Back-to-back mispredictions are impossible: the second falls in the flush cycle and is ignored.

Decomposition:
- Shared package holds:
  - constants DATA_WIDTH, INDEX_BITS, TAG_BITS;
  - typedef btb_entry_t {valid, tag, target};
  - typedef bht_ctr_t as logic[1:0], with constants SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, `bht_sat_counter_table`: the 2-bit counter array with a combinational read port, a synchronous update port and reset-to-WNT.

Test Plan:
1. Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; rst_out=0; both counters 0.
2. Resolve branch ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0 -> rst_out=1 for one cycle next cycle, redirect_pc=0x200, mispredict_count=1. Then if_pc=0x100 -> pred_taken=1, pred_target=0x200.
3. Same branch resolved taken 3 more times, correct prediction -> no rst_out, counter saturates at 11. Then resolve not-taken -> flush, redirect_pc=0x104; next lookup still predicts taken (counter 10).
4. Correct direction but wrong target (pred 0x200, actual 0x300) -> flush, redirect_pc=0x300, BTB target becomes 0x300.
5. Mispredict at cycle N followed by another mispredict in cycle N+1 -> the second is ignored; mispredict_count +1 only.
6. Assert rst_BF in the same cycle a mispredict resolves -> rst_out=0 next cycle, both counters 0, if_pc=0x100 predicts not-taken.
